// File: rtl/dmem_mmio.sv
// Data memory for the single-cycle core: word RAM plus an I/O page with a
// compare timer and a TX byte FIFO. Define MMIO_TIMER_EN to build the timer.
module dmem_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);

  logic [31:0]   ram [RAM_WORDS];
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          ovf;

  logic          is_ram;
  logic          is_io;
  logic [5:0]    off;
  logic [AW-1:0] ridx;
  logic          wr_ram;
  logic          wr_io;
  logic          wr_status;
  logic          push;
  logic          pop;
  logic          accept;
  logic          full;
  logic          empty;
  logic [31:0]   rd_count;
  logic [31:0]   rd_cmp;
  logic          irq;
  logic          unused;

  assign unused    = ^addr[1:0];
  assign is_ram    = ~addr[31];
  assign is_io     = addr[31:8] == 24'hFFFFFF;
  assign off       = addr[7:2];
  assign ridx      = addr[AW+1:2];
  assign wr_ram    = memwrite & is_ram;
  assign wr_io     = memwrite & is_io;
  assign wr_status = wr_io && off == 6'd2;
  assign push      = wr_io && off == 6'd3;

  assign full     = cnt == FULL_C;
  assign empty    = cnt == '0;
  assign tx_valid = ~empty;
  assign tx_data  = empty ? 8'h00 : fifo[rd_ptr];
  assign pop      = tx_valid & tx_ready;
  // a pop in the same cycle frees the slot the push needs
  assign accept   = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_ram) ram[ridx] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (accept) fifo[wr_ptr] <= writedata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (accept & ~pop) cnt <= cnt + CW'(1);
      else if (pop & ~accept) cnt <= cnt - CW'(1);
      if (push & ~accept) ovf <= 1'b1;
      else if (wr_status & writedata[3]) ovf <= 1'b0;
    end
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] count_q;
  logic [31:0] cmp_q;
  logic        irq_q;
  logic        wr_count;
  logic        wr_cmp;
  logic        hit;

  assign wr_count = wr_io && off == 6'd0;
  assign wr_cmp   = wr_io && off == 6'd1;
  assign hit      = (cmp_q != '0) && (count_q == cmp_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      cmp_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (wr_count) count_q <= writedata;
      else if (hit) count_q <= '0;
      else count_q <= count_q + 32'd1;
      if (wr_cmp) cmp_q <= writedata;
      // a fresh match outranks a same-cycle clear
      if (~wr_count & hit) irq_q <= 1'b1;
      else if (wr_status & writedata[0]) irq_q <= 1'b0;
    end
  end

  assign rd_count = count_q;
  assign rd_cmp   = cmp_q;
  assign irq      = irq_q;
`else
  assign rd_count = '0;
  assign rd_cmp   = '0;
  assign irq      = 1'b0;
`endif

  assign timer_irq = irq;

  always_comb begin
    readdata = '0;
    if (is_ram) begin
      readdata = ram[ridx];
    end else if (is_io) begin
      case (off)
        6'd0:    readdata = rd_count;
        6'd1:    readdata = rd_cmp;
        6'd2:    readdata = {28'b0, ovf, empty, full, irq};
        6'd3:    readdata = {{(32-CW){1'b0}}, cnt};
        default: readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: RAM decode, TX FIFO, timer (when built
// with MMIO_TIMER_EN) and asynchronous reset.
module tb_dmem_mmio;

  localparam logic [31:0] IO    = 32'hFFFFFF00;
  localparam logic [31:0] COUNT = IO + 32'h0;
  localparam logic [31:0] CMP   = IO + 32'h4;
  localparam logic [31:0] STAT  = IO + 32'h8;
  localparam logic [31:0] TXD   = IO + 32'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        timer_irq;

  int errs = 0;
  int nchk = 0;
  logic [31:0] rdq [$];
  logic [7:0]  txq [$];

  dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
    .writedata(writedata), .readdata(readdata), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic ld(input string tag, input logic [31:0] a,
                    input logic [31:0] e);
    rdq.push_back(e);
    memwrite = 1'b0;
    addr = a;
    #1;
    chk(tag, readdata, rdq.pop_front());
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    writedata = d;
    memwrite = 1'b1;
    @(negedge clk);
    memwrite = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] b, input bit acc);
    st(TXD, {24'h0, b});
    if (acc) txq.push_back(b);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    @(negedge clk);
    tx_ready = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      if (tx_valid) begin
        if (txq.size() == 0) chk("tx_extra", 1, 0);
        else chk("tx_byte", tx_data, txq.pop_front());
      end
      @(negedge clk);
      #1;
    end
    tx_ready = 1'b0;
    chk("txq_left", txq.size(), 0);
    chk("tx_valid_end", tx_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    memwrite = 1'b0;
    addr = '0;
    writedata = '0;
    tx_ready = 1'b0;
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_irq", timer_irq, 0);
    ld("rst_status", STAT, 32'h4);
    ld("rst_occ", TXD, 32'h0);
    ld("rst_count", COUNT, 32'h0);
    ld("rst_cmp", CMP, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cycles(1);

    // RAM decode and aliasing
    st(32'h0000_0010, 32'hDEADBEEF);
    st(32'h0000_0000, 32'h12345678);
    ld("ram_rd", 32'h0000_0010, 32'hDEADBEEF);
    ld("ram_alias", 32'h0000_0110, 32'hDEADBEEF);
    ld("ram_alias_hi", 32'h4000_0000, 32'h12345678);
    st(32'h8000_0004, 32'h55AA55AA);
    ld("hole_rd", 32'h8000_0004, 32'h0);
    st(IO + 32'h40, 32'h1);
    ld("io_unused", IO + 32'h40, 32'h0);

    // overflow: fifth push dropped
    push_tx(8'h41, 1);
    push_tx(8'h42, 1);
    push_tx(8'h43, 1);
    push_tx(8'h44, 1);
    push_tx(8'h45, 0);
    ld("occ_full", TXD, 32'h4);
    ld("status_full_ovf", STAT, 32'hA);
    chk("head", tx_data, 8'h41);
    drain();
    ld("status_drained", STAT, 32'hC);
    st(STAT, 32'h8);
    ld("ovf_w1c", STAT, 32'h4);

    // push into full FIFO while popping
    push_tx(8'h50, 1);
    push_tx(8'h51, 1);
    push_tx(8'h52, 1);
    push_tx(8'h53, 1);
    tx_ready = 1'b1;
    addr = TXD;
    writedata = 32'h54;
    memwrite = 1'b1;
    #1;
    chk("pp_head", tx_data, txq.pop_front());
    txq.push_back(8'h54);
    @(negedge clk);
    memwrite = 1'b0;
    tx_ready = 1'b0;
    ld("pp_occ", TXD, 32'h4);
    ld("pp_status", STAT, 32'h2);
    drain();

`ifdef MMIO_TIMER_EN
    st(CMP, 32'd5);
    st(COUNT, 32'd0);
    ld("cnt0", COUNT, 32'd0);
    chk("irq_pre", timer_irq, 0);
    cycles(4);
    ld("cnt4", COUNT, 32'd4);
    cycles(1);
    ld("cnt5", COUNT, 32'd5);
    chk("irq_cnt5", timer_irq, 0);
    cycles(1);
    chk("irq_match", timer_irq, 1);
    ld("status_irq", STAT, 32'h5);
    ld("cnt_wrap", COUNT, 32'd0);
    st(STAT, 32'h1);
    chk("irq_w1c", timer_irq, 0);
    ld("cnt_after", COUNT, 32'd1);
    st(COUNT, 32'd3);
    cycles(2);
    st(STAT, 32'h1);
    chk("irq_set_wins", timer_irq, 1);
    ld("cnt_hit2", COUNT, 32'd0);
    st(STAT, 32'h1);
    chk("irq_clr2", timer_irq, 0);

    st(CMP, 32'd0);
    st(COUNT, 32'hFFFFFFFF);
    ld("cnt_max", COUNT, 32'hFFFFFFFF);
    cycles(1);
    ld("cnt_rollover", COUNT, 32'd0);
    chk("irq_rollover", timer_irq, 0);
    st(CMP, 32'd7);
    st(COUNT, 32'd6);
    cycles(1);
    ld("cnt7", COUNT, 32'd7);
    st(COUNT, 32'h100);
    ld("store_wins", COUNT, 32'h100);
    chk("irq_store_wins", timer_irq, 0);
    ld("cmp_rd", CMP, 32'd7);
    st(CMP, 32'd0);
`else
    st(COUNT, 32'd7);
    ld("notimer_count", COUNT, 32'd0);
    st(CMP, 32'd9);
    ld("notimer_cmp", CMP, 32'd0);
    cycles(3);
    chk("notimer_irq", timer_irq, 0);
    ld("notimer_status", STAT, 32'h4);
`endif

    // asynchronous reset in the middle of a drain
    push_tx(8'h60, 1);
    push_tx(8'h61, 1);
    st(32'h0000_0020, 32'hCAFEF00D);
    tx_ready = 1'b1;
    #1;
    chk("md_head0", tx_data, txq.pop_front());
    @(negedge clk);
    #1;
    chk("md_head1", tx_data, txq[0]);
    #2;
    reset = 1'b1;
    #1;
    txq.delete();
    chk("ar_tx_valid", tx_valid, 0);
    chk("ar_tx_data", tx_data, 0);
    chk("ar_irq", timer_irq, 0);
    ld("ar_status", STAT, 32'h4);
    ld("ar_occ", TXD, 32'h0);
    ld("ar_ram", 32'h0000_0020, 32'hCAFEF00D);
    ld("ar_ram2", 32'h0000_0010, 32'hDEADBEEF);
    tx_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cycles(2);
    chk("post_tx_valid", tx_valid, 0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
